// File: rtl/rf_wport_if.sv
// Register-file write-port arbiter bus: WB write, long-latency result return,
// issue tracking, RF write port and status outputs.
// slave = arbiter side, master = pipeline / environment side.
interface rf_wport_if #(
  parameter int DEPTH = 2
);
  logic                     ws_we;
  logic [4:0]               ws_waddr;
  logic [31:0]              ws_wdata;
  logic                     lu_valid;
  logic                     lu_ready;
  logic [4:0]               lu_waddr;
  logic [31:0]              lu_wdata;
  logic                     issue_valid;
  logic [4:0]               issue_dest;
  logic                     rf_we;
  logic [4:0]               rf_waddr;
  logic [31:0]              rf_wdata;
  logic [31:0]              busy_mask;
  logic                     lu_starve;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  ws_we, ws_waddr, ws_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  issue_valid, issue_dest,
    output lu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output busy_mask, lu_starve, fifo_count
  );

  modport master (
    output ws_we, ws_waddr, ws_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output issue_valid, issue_dest,
    input  lu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy_mask, lu_starve, fifo_count
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the single RF write port between write-back (absolute priority) and
// a long-latency unit whose results are buffered in a small FIFO and drained
// into idle port cycles. Tracks pending long-latency destinations in a
// 32-bit scoreboard and raises lu_starve when the FIFO is denied too long.
// Optional macro RF_WPORT_BYPASS_EN: an arriving result is written straight
// through when the FIFO is empty and WB is idle.
module rf_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic      clk,
  input logic      reset,
  rf_wport_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    mem_waddr_q [DEPTH];
  logic [31:0]   mem_wdata_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_q, starve_d;

  logic          lu_ready;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [4:0]    head_waddr;
  logic [31:0]   head_wdata;

  assign empty      = (count_q == '0);
  assign lu_ready   = !reset && (count_q < CW'(DEPTH));
  assign head_waddr = mem_waddr_q[rd_ptr_q];
  assign head_wdata = mem_wdata_q[rd_ptr_q];
  assign push       = bus.lu_valid && lu_ready && !bypass;

  // Port mux: WB first, then FIFO head, then (optionally) the arriving result.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = bus.ws_waddr;
    rf_wdata = bus.ws_wdata;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (bus.ws_we) begin
      rf_we = 1'b1;
    end else if (!empty) begin
      // A $0 entry still drains but never reaches the RF.
      rf_we    = (head_waddr != 5'd0);
      rf_waddr = head_waddr;
      rf_wdata = head_wdata;
      pop      = 1'b1;
    end
`ifdef RF_WPORT_BYPASS_EN
    else if (bus.lu_valid && lu_ready) begin
      rf_we    = (bus.lu_waddr != 5'd0);
      rf_waddr = bus.lu_waddr;
      rf_wdata = bus.lu_wdata;
      bypass   = 1'b1;
    end
`endif
    if (reset) begin
      rf_we = 1'b0;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap since DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Scoreboard next-state: clears first so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_waddr] = 1'b0;
    end
    if (bypass) begin
      busy_d[bus.lu_waddr] = 1'b0;
    end
    if (bus.issue_valid) begin
      busy_d[bus.issue_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation counter: counts denied cycles, saturating, cleared by a pop.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop || empty) begin
      starve_cnt_d = '0;
    end else if (bus.ws_we && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
    starve_d = (starve_cnt_d == SW'(STARVE_LIMIT));
  end

  // Control state registers; reset discards buffered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  // FIFO storage: data only, no reset needed since occupancy guards it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_waddr_q[wr_ptr_q] <= bus.lu_waddr;
      mem_wdata_q[wr_ptr_q] <= bus.lu_wdata;
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.busy_mask  = busy_q;
  assign bus.lu_starve  = starve_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized scoreboard bench for rf_wport_arbiter with a queue-based
// reference model; honours RF_WPORT_BYPASS_EN the same way as the design.
module tb_rf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_wport_if #(.DEPTH(DEPTH)) bus ();
  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    bit        we;
    bit        rdy;
    bit [31:0] busy;
    bit        starve;
    int        count;
    bit        known;
  } st_t;

  wr_t exp_wr[$];
  st_t exp_st[$];
  wr_t mfifo[$];

  bit [31:0] m_busy;
  int        m_den;
  bit        m_starve;
  bit        m_known;
  int        nvec;
  int        nerr;
  bit [4:0]  last_issue;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, derive expected response from the model.
  task automatic cycle(input bit rst, input bit ws, input bit [4:0] wa, input bit [31:0] wd,
                       input bit lv, input bit [4:0] la, input bit [31:0] ld,
                       input bit iv, input bit [4:0] id);
    st_t      st;
    wr_t      h;
    bit       popped;
    bit       byp;
    bit [4:0] clr;
    int       sz;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.ws_we       = ws;
    bus.ws_waddr    = wa;
    bus.ws_wdata    = wd;
    bus.lu_valid    = lv;
    bus.lu_waddr    = la;
    bus.lu_wdata    = ld;
    bus.issue_valid = iv;
    bus.issue_dest  = id;
    popped = 1'b0;
    byp    = 1'b0;
    clr    = 5'd0;
    sz     = mfifo.size();
    st.known  = m_known;
    st.busy   = m_busy;
    st.starve = m_starve;
    st.count  = sz;
    if (rst) begin
      st.we  = 1'b0;
      st.rdy = 1'b0;
      mfifo.delete();
      m_busy   = '0;
      m_den    = 0;
      m_starve = 1'b0;
      m_known  = 1'b1;
    end else begin
      st.rdy = (sz < DEPTH);
      st.we  = 1'b0;
      if (ws) begin
        st.we = 1'b1;
        exp_wr.push_back({wa, wd});
      end else if (sz > 0) begin
        h      = mfifo.pop_front();
        popped = 1'b1;
        clr    = h.a;
        st.we  = (h.a != 5'd0);
        if (st.we) exp_wr.push_back(h);
      end
`ifdef RF_WPORT_BYPASS_EN
      else if (lv) begin
        byp   = 1'b1;
        clr   = la;
        st.we = (la != 5'd0);
        if (st.we) exp_wr.push_back({la, ld});
      end
`endif
      if (lv && st.rdy && !byp) mfifo.push_back({la, ld});
      if (popped || byp) m_busy[clr] = 1'b0;
      if (iv) m_busy[id] = 1'b1;
      m_busy[0] = 1'b0;
      if (popped || sz == 0) m_den = 0;
      else if (ws && m_den < LIMIT) m_den++;
      m_starve = (m_den == LIMIT);
    end
    exp_st.push_back(st);
  endtask

  // Monitor: pops expectations and compares mid-cycle, away from the edge.
  always @(negedge clk) begin
    st_t e;
    wr_t w;
    if (exp_st.size() > 0) begin
      e = exp_st.pop_front();
      chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
      chk("lu_ready", {31'd0, bus.lu_ready}, {31'd0, e.rdy});
      if (e.known) begin
        chk("busy_mask", bus.busy_mask, e.busy);
        chk("lu_starve", {31'd0, bus.lu_starve}, {31'd0, e.starve});
        chk("fifo_count", 32'(bus.fifo_count), 32'(e.count));
      end
      if (bus.rf_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL rf_write @%0t: unexpected write %h/%h, none expected",
                   $time, bus.rf_waddr, bus.rf_wdata);
        end else begin
          w = exp_wr.pop_front();
          chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, w.a});
          chk("rf_wdata", bus.rf_wdata, w.d);
        end
      end
    end
  end

  function automatic bit [4:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)      return last_issue;
    else if (r < 5) return 5'd0;
    else if (r < 8) return 5'($urandom_range(1, 9));
    else            return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int  mode;
    bit  ws, lv, iv, rs;
    bit [4:0] id;
    nvec       = 0;
    nerr       = 0;
    m_known    = 1'b0;
    m_busy     = '0;
    m_den      = 0;
    m_starve   = 1'b0;
    last_issue = 5'd7;
    // Reset, then the directed scenarios.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 5'd7, 32'hA5A5A5A5, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 5'd1, 32'h100 + i, i < 2, 5'd10 + 5'(i), 32'h200 + i, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 5'd2, 32'h300 + i, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd11);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Same-cycle set and clear of $9, then a $0 result.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    cycle(0, 1, 5'd3, 32'h1, 1, 5'd9, 32'h99, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    cycle(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset with two entries buffered and busy bits 7 and 10.
    cycle(0, 1, 5'd4, 32'h4, 1, 5'd7, 32'h77, 1, 5'd7);
    cycle(0, 1, 5'd4, 32'h5, 1, 5'd10, 32'hAA, 1, 5'd10);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized phases.
    mode = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (c % 24 == 0) mode = $urandom_range(0, 3);
      case (mode)
        0:       ws = ($urandom_range(0, 1) == 1);
        1:       ws = 1'b1;
        2:       ws = 1'b0;
        default: ws = ($urandom_range(0, 3) == 0);
      endcase
      lv = ($urandom_range(0, 2) != 0);
      iv = ($urandom_range(0, 2) == 0);
      id = 5'($urandom_range(0, 12));
      rs = ($urandom_range(0, 299) == 0);
      cycle(rs, ws, 5'($urandom), $urandom, lv, pick_addr(), $urandom, iv, id);
      if (iv && id != 5'd0) last_issue = id;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order write-back stage and one long-latency unit (mul/div result return).
- WB writes have absolute priority and are never back-pressured. Long-latency results are buffered in a small FIFO and drained into idle write-port cycles.
- Keeps a 32-bit scoreboard of destination registers with outstanding long-latency results. Decode uses it for interlock.

Parameters:
- DEPTH, 2: long-latency result FIFO entries; power of 2, >= 2.
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO may be denied the port before lu_starve asserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_we  in  1  WB write request (already qualified by ws_valid)
- ws_waddr  in  5  WB destination
- ws_wdata  in  32  WB data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  arbiter can accept a result
- lu_waddr  in  5  result destination
- lu_wdata  in  32  result data
- issue_valid  in  1  long-latency op issued this cycle
- issue_dest  in  5  its destination register
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- busy_mask  out  32  scoreboard; bit n = result pending for $n
- lu_starve  out  1  request to the pipeline for one WB bubble
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: FIFO empty, fifo_count=0, busy_mask=0, starve counter=0, lu_starve=0, lu_ready=0. rf_we is forced 0 while reset is high.
- lu_ready = !reset && (fifo_count < DEPTH). A push occurs when lu_valid && lu_ready, and the entry is written at the clk edge.
- Port mux (combinational on the current cycle):
  - If ws_we: rf_* = ws_*.
  - Else if the FIFO is non-empty: rf_* = head entry, the entry is popped at the clk edge, and rf_we = (head.waddr != 0).
  - Else: rf_we = 0.
- An entry with waddr 0 is still popped and clears nothing.
- Push and pop in the same cycle: count is unchanged. A push is allowed when count == DEPTH only if lu_ready, so never at full. The pointers wrap modulo DEPTH.
- Latency: a result pushed in cycle t is written no earlier than t+1.
- Scoreboard, at each clk edge:
  - issue_valid && issue_dest != 0 sets bit issue_dest.
  - A pop clears bit head.waddr.
  - If the same register is set and cleared in the same cycle, set wins.
  - Bit 0 is always 0.
  - busy_mask is registered.
- Starve counter:
  - Increments when the FIFO is non-empty and ws_we = 1. It saturates at STARVE_LIMIT.
  - Resets to 0 on any pop or when the FIFO is empty.
  - lu_starve = (counter == STARVE_LIMIT), registered. It deasserts the cycle after the pop.
- WAW ordering between WB and a pending register is the decode stage's job: it must stall on busy_mask. The arbiter does not check it.
- Reset mid-operation discards buffered results and clears the scoreboard.

Optional Feature:
- Macro: RF_WPORT_BYPASS_EN
- Defined: when the FIFO is empty, ws_we = 0 and lu_valid = 1, the result is written to the RF in the same cycle and not pushed. lu_ready is still asserted. The scoreboard bit clears at that edge, and set still wins if issue targets the same register.
- Undefined: every result passes through the FIFO (minimum 1-cycle latency).

Test Plan:
- Idle FIFO; ws_we=1, waddr=5, wdata=0x1234 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 in the same cycle; fifo_count=0.
- issue_dest=7, then 3 cycles later an lu push (waddr=7, data=0xA5A5A5A5) with ws_we=0 -> busy_mask[7]=1 until the pop. rf write of 7/0xA5A5A5A5 one cycle after the push (same cycle with BYPASS_EN), and busy_mask[7]=0 after that edge.
- ws_we held at 1 while 2 lu results are pushed -> fifo_count=2 and lu_ready=0. Drop ws_we -> both written in push order on consecutive cycles.
- ws_we held for 10 cycles with the FIFO non-empty -> lu_starve=1 from the cycle after the counter reaches 8. It clears the cycle after the first pop.
- issue_dest=9 in the same cycle as a pop of waddr 9 -> busy_mask[9] stays 1. An lu result to $0 -> rf_we=0, popped, busy_mask unchanged.
- Reset asserted with 2 entries buffered and busy_mask=0x0000_0480 -> next cycle fifo_count=0, busy_mask=0, rf_we=0.
